// File: rtl/buttons_in.sv
// Memory-mapped push-button input: 2-flop sync, per-bit debounce, sticky W1C edge flags.
// Define BUTTONS_IRQ_EN to add the registered level-sensitive irq output.
module buttons_in #(
   parameter logic [31:0] BASE_ADDR       = 32'h0000_2000,
   parameter int unsigned WIDTH           = 8,
   parameter int unsigned DEBOUNCE_CYCLES = 1000,
   parameter int unsigned CNT_W           = 16
) (
   input  logic             clk,
   input  logic             reset,
   inout  wire logic [31:0] data_bus_data,
   input  logic [31:0]      data_bus_addr,
   input  logic [1:0]       data_bus_mode,
   input  logic [WIDTH-1:0] buttons_in_pins
`ifdef BUTTONS_IRQ_EN
   ,
   output logic             irq
`endif
);

   typedef enum logic [1:0] {
      MODE_IDLE  = 2'b00,
      MODE_READ  = 2'b01,
      MODE_WRITE = 2'b10,
      MODE_RSVD  = 2'b11
   } bus_mode_e;

   typedef enum logic [1:0] {
      REG_STATE  = 2'd0,
      REG_RISE   = 2'd1,
      REG_FALL   = 2'd2,
      REG_IRQ_EN = 2'd3
   } reg_sel_e;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   bus_mode_e        mode;
   reg_sel_e         reg_sel;
   logic             sel, rd_en, wr_en;
   logic [WIDTH-1:0] wdata;
   logic [31:0]      rd_data;
   logic             unused_bits;

   logic [WIDTH-1:0] sync1, sync2, stable, stable_nxt;
   logic [CNT_W-1:0] cnt     [WIDTH];
   logic [CNT_W-1:0] cnt_nxt [WIDTH];
   logic [WIDTH-1:0] rise, fall, rise_clr, fall_clr;
   logic [1:0]       irq_en;

   assign mode    = bus_mode_e'(data_bus_mode);
   assign reg_sel = reg_sel_e'(data_bus_addr[3:2]);
   assign sel     = (data_bus_addr[31:4] == BASE_ADDR[31:4]);
   assign rd_en   = sel && (mode == MODE_READ);
   assign wr_en   = sel && (mode == MODE_WRITE);
   assign wdata   = data_bus_data[WIDTH-1:0];

   // Byte-lane bits and upper data bits carry no meaning for this block.
   assign unused_bits = ^{data_bus_addr[1:0], data_bus_data};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= buttons_in_pins;
         sync2 <= sync1;
      end
   end

   always_comb begin
      stable_nxt = stable;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         cnt_nxt[i] = '0;
         if (sync2[i] != stable[i]) begin
            if (cnt[i] == CNT_LAST)
               stable_nxt[i] = sync2[i];
            else
               cnt_nxt[i] = cnt[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stable <= '0;
         for (int unsigned i = 0; i < WIDTH; i++)
            cnt[i] <= '0;
      end else begin
         stable <= stable_nxt;
         for (int unsigned i = 0; i < WIDTH; i++)
            cnt[i] <= cnt_nxt[i];
      end
   end

   assign rise_clr = (wr_en && reg_sel == REG_RISE) ? wdata : '0;
   assign fall_clr = (wr_en && reg_sel == REG_FALL) ? wdata : '0;

   // New edges are OR'd in after the clear so a same-edge set survives the W1C.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rise   <= '0;
         fall   <= '0;
         irq_en <= '0;
      end else begin
         rise <= (rise & ~rise_clr) | (stable_nxt & ~stable);
         fall <= (fall & ~fall_clr) | (~stable_nxt & stable);
         if (wr_en && reg_sel == REG_IRQ_EN)
            irq_en <= data_bus_data[1:0];
      end
   end

   always_comb begin
      rd_data = '0;
      case (reg_sel)
         REG_STATE:  rd_data[WIDTH-1:0] = stable;
         REG_RISE:   rd_data[WIDTH-1:0] = rise;
         REG_FALL:   rd_data[WIDTH-1:0] = fall;
         REG_IRQ_EN: rd_data[1:0]       = irq_en;
         default:    rd_data            = '0;
      endcase
   end

   assign data_bus_data = rd_en ? rd_data : 'z;

`ifdef BUTTONS_IRQ_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         irq <= 1'b0;
      else
         irq <= (irq_en[0] & (|rise)) | (irq_en[1] & (|fall));
   end
`endif

endmodule
